if_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues one word request at a time to instruction memory. Responses pass through a one-entry hold buffer into a registered pc/inst output that decode consumes, and the stage applies branch redirects that decode reports.

---
 rtl/if_stage.sv | 187 ++++++++++++++++++
 tb/tb_if_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage in front of decode. Owns the program counter and
//   keeps at most one word request in flight to instruction memory. Returned
//   words go to a registered pc/inst output slot, or into a one-entry hold
//   buffer when decode is stalled. Branch redirects reported by decode
//   restart fetch at the new target.
//
// Ports
//   clk          clock, rising-edge
//   reset_n      asynchronous active-low reset
//   id_stall     decode cannot take the current output this cycle
//   br           decode reports a taken branch for the instruction on inst_out
//   branch_addr  redirect target (low two bits ignored)
//   imem_req     one-cycle request pulse to instruction memory
//   imem_addr    word-aligned request address
//   imem_rvalid  response strobe from instruction memory
//   imem_rdata   instruction word returned with imem_rvalid
//   pc_out       pc of inst_out
//   inst_out     instruction to decode (NOP_INST while inst_valid=0)
//   inst_valid   pc_out/inst_out carry a real instruction
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | first cycle after reset, nothing issued yet
// S_REQ  | imem_req asserted for fetch_pc; hold buffer empty
// S_WAIT | request in flight, waiting for imem_rvalid
// S_HOLD | fetched word parked in hold buffer until decode consumes output
// S_DROP | request in flight belongs to a squashed path; discard response
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_stall,
  input  logic        br,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] hold_inst, hold_inst_nxt;
  logic        inst_valid_nxt;
  logic [31:0] pc_out_nxt;
  logic [31:0] inst_out_nxt;

  logic        consume;
  logic        redirect;
  logic        slot_free;
  logic [31:0] target_pc;
  logic        unused_addr_bits;

  assign consume   = inst_valid & ~id_stall;
  assign redirect  = br & consume;
  assign slot_free = ~inst_valid | consume;
  assign target_pc = {branch_addr[31:2], 2'b00};

  // Byte offset of a branch target is irrelevant to a word fetch.
  assign unused_addr_bits = ^branch_addr[1:0];

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    hold_valid_nxt = hold_valid;
    hold_pc_nxt    = hold_pc;
    hold_inst_nxt  = hold_inst;
    inst_valid_nxt = inst_valid;
    pc_out_nxt     = pc_out;
    inst_out_nxt   = inst_out;

    // Decode took the current word; the slot empties unless refilled below.
    // pc_out deliberately keeps its last value.
    if (consume) begin
      inst_valid_nxt = 1'b0;
      inst_out_nxt   = NOP_INST;
    end

    case (state)
      S_IDLE: state_nxt = S_REQ;

      S_REQ: state_nxt = S_WAIT;

      S_WAIT: begin
        if (imem_rvalid) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          if (slot_free) begin
            inst_valid_nxt = 1'b1;
            pc_out_nxt     = fetch_pc;
            inst_out_nxt   = imem_rdata;
            state_nxt      = S_REQ;
          end else begin
            hold_valid_nxt = 1'b1;
            hold_pc_nxt    = fetch_pc;
            hold_inst_nxt  = imem_rdata;
            state_nxt      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // An empty buffer here cannot happen in normal operation; fall back
        // to fetching rather than waiting forever.
        if (!hold_valid) begin
          state_nxt = S_REQ;
        end else if (consume) begin
          inst_valid_nxt = 1'b1;
          pc_out_nxt     = hold_pc;
          inst_out_nxt   = hold_inst;
          hold_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
      end

      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end

      default: state_nxt = S_IDLE;
    endcase

    // Redirect overrides everything decided above for this cycle, including
    // any word that arrives in the same cycle.
    if (redirect) begin
      fetch_pc_nxt   = target_pc;
      inst_valid_nxt = 1'b0;
      inst_out_nxt   = NOP_INST;
      pc_out_nxt     = pc_out;
      hold_valid_nxt = 1'b0;
      case (state)
        S_REQ:   state_nxt = S_DROP;
        S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_nxt = imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC_W;
      hold_valid <= 1'b0;
      hold_pc    <= RESET_PC_W;
      hold_inst  <= NOP_INST;
      inst_valid <= 1'b0;
      pc_out     <= RESET_PC_W;
      inst_out   <= NOP_INST;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC_W;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      hold_valid <= hold_valid_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_inst  <= hold_inst_nxt;
      inst_valid <= inst_valid_nxt;
      pc_out     <= pc_out_nxt;
      inst_out   <= inst_out_nxt;
      // Request is registered: it is high exactly while the FSM sits in S_REQ.
      imem_req   <= (state_nxt == S_REQ);
      imem_addr  <= fetch_pc_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        id_stall;
  logic        br;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_lat = 1;
  int pend = 0;
  logic [31:0] pend_addr;
  logic [63:0] exp_q[$];

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_stall   (id_stall),
    .br         (br),
    .branch_addr(branch_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .inst_valid (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_cycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic mid_cycle(input int n);
    start_cycle(n);
    @(negedge clk);
  endtask

  task automatic enter_reset(input int lat);
    id_stall = 1'b0;
    br       = 1'b0;
    reset_n  = 1'b0;
    mem_lat  = lat;
    exp_q.delete();
  endtask

  // Cycle 1 is the cycle in which reset_n rises.
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(reset_n && inst_valid) && n < budget);
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst_out, NOP);
    chk({tag, "_pc"},    pc_out, 32'h0);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
  endtask

  // Instruction memory: one response 'mem_lat' cycles after each request.
  // Also flags a second request while one is still outstanding.
  initial begin : mem_model
    bit busy;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend_addr   = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (!reset_n) begin
        pend = 0;
      end else begin
        busy = (pend != 0);
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
          end
        end
        if (imem_req) begin
          chk("req_while_outstanding", 32'(busy), 32'd0);
          chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
          pend      = mem_lat;
          pend_addr = imem_addr;
        end
      end
    end
  end

  // Scoreboard: every word decode accepts must be the next expected one.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (!inst_valid) begin
          chk("nop_when_invalid", inst_out, NOP);
        end else if (!id_stall) begin
          chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", pc_out, e[63:32]);
            chk("sb_inst", inst_out, e[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n;
    bit  found;
    reset_n     = 1'b1;
    id_stall    = 1'b0;
    br          = 1'b0;
    branch_addr = 32'h0;

    // Phase 1: reset values, then latency-1 streaming
    #3;
    enter_reset(1);
    @(negedge clk);
    chk_reset_vals("rst");
    push_exp(32'h0);
    push_exp(32'h4);
    release_reset();
    mid_cycle(1);
    chk("p1_c1_req", 32'(imem_req), 32'd0);
    mid_cycle(2);
    chk("p1_c2_req", 32'(imem_req), 32'd1);
    chk("p1_c2_addr", imem_addr, 32'h0);
    mid_cycle(3);
    chk("p1_c3_req", 32'(imem_req), 32'd0);
    chk("p1_c3_valid", 32'(inst_valid), 32'd0);
    mid_cycle(4);
    chk("p1_c4_req", 32'(imem_req), 32'd1);
    chk("p1_c4_addr", imem_addr, 32'h4);
    chk("p1_c4_valid", 32'(inst_valid), 32'd1);
    chk("p1_c4_pc", pc_out, 32'h0);
    chk("p1_c4_inst", inst_out, 32'h0050_0093);
    mid_cycle(5);
    chk("p1_c5_valid", 32'(inst_valid), 32'd0);
    chk("p1_c5_pc_hold", pc_out, 32'h0);
    mid_cycle(6);
    chk("p1_c6_valid", 32'(inst_valid), 32'd1);
    chk("p1_c6_pc", pc_out, 32'h4);
    chk("p1_c6_inst", inst_out, 32'h00A0_0113);
    start_cycle(7);
    id_stall = 1'b1;
    chk("p1_drain", 32'(exp_q.size()), 32'd0);

    // Phase 2: five-cycle stall with first word visible
    enter_reset(1);
    push_exp(32'h0);
    push_exp(32'h4);
    release_reset();
    start_cycle(4);
    id_stall = 1'b1;
    mid_cycle(4);
    chk("p2_c4_req", 32'(imem_req), 32'd1);
    chk("p2_c4_addr", imem_addr, 32'h4);
    n = 0;
    for (int c = 5; c <= 8; c++) begin
      mid_cycle(c);
      if (imem_req) n++;
    end
    chk("p2_extra_reqs", 32'(n), 32'd0);
    chk("p2_frozen_valid", 32'(inst_valid), 32'd1);
    chk("p2_frozen_pc", pc_out, 32'h0);
    start_cycle(9);
    id_stall = 1'b0;
    mid_cycle(10);
    chk("p2_c10_valid", 32'(inst_valid), 32'd1);
    chk("p2_c10_pc", pc_out, 32'h4);
    chk("p2_c10_inst", inst_out, 32'h00A0_0113);
    chk("p2_c10_req", 32'(imem_req), 32'd1);
    chk("p2_c10_addr", imem_addr, 32'h8);
    start_cycle(11);
    id_stall = 1'b1;
    chk("p2_drain", 32'(exp_q.size()), 32'd0);

    // Phase 3: redirect while request for 8 is outstanding
    enter_reset(1);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h40);
    release_reset();
    start_cycle(6);
    br = 1'b1;
    branch_addr = 32'h40;
    mid_cycle(6);
    chk("p3_c6_pc", pc_out, 32'h4);
    chk("p3_c6_addr", imem_addr, 32'h8);
    start_cycle(7);
    br = 1'b0;
    mid_cycle(7);
    chk("p3_c7_valid", 32'(inst_valid), 32'd0);
    chk("p3_c7_pc_hold", pc_out, 32'h4);
    chk("p3_c7_req", 32'(imem_req), 32'd0);
    mid_cycle(8);
    chk("p3_c8_req", 32'(imem_req), 32'd1);
    chk("p3_c8_addr", imem_addr, 32'h40);
    mid_cycle(10);
    chk("p3_c10_valid", 32'(inst_valid), 32'd1);
    chk("p3_c10_pc", pc_out, 32'h40);
    start_cycle(11);
    id_stall = 1'b1;
    chk("p3_drain", 32'(exp_q.size()), 32'd0);

    // Phase 4: br ignored under stall, taken after stall drops (0x43 -> 0x40)
    enter_reset(1);
    push_exp(32'h0);
    push_exp(32'h40);
    release_reset();
    start_cycle(4);
    id_stall = 1'b1;
    br = 1'b1;
    branch_addr = 32'h80;
    mid_cycle(4);
    chk("p4_c4_req", 32'(imem_req), 32'd1);
    chk("p4_c4_addr", imem_addr, 32'h4);
    mid_cycle(6);
    chk("p4_c6_valid", 32'(inst_valid), 32'd1);
    chk("p4_c6_pc", pc_out, 32'h0);
    chk("p4_c6_req", 32'(imem_req), 32'd0);
    start_cycle(7);
    id_stall = 1'b0;
    branch_addr = 32'h43;
    start_cycle(8);
    br = 1'b0;
    mid_cycle(8);
    chk("p4_c8_valid", 32'(inst_valid), 32'd0);
    chk("p4_c8_req", 32'(imem_req), 32'd1);
    chk("p4_c8_addr", imem_addr, 32'h40);
    mid_cycle(10);
    chk("p4_c10_valid", 32'(inst_valid), 32'd1);
    chk("p4_c10_pc", pc_out, 32'h40);
    start_cycle(11);
    id_stall = 1'b1;
    chk("p4_drain", 32'(exp_q.size()), 32'd0);

    // Phase 5: reset asserted while waiting on the response for 0x10
    enter_reset(3);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    push_exp(32'hC);
    release_reset();
    n = 0;
    found = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      found = imem_req && (imem_addr == 32'h10);
    end
    chk("p5_reach_0x10", 32'(found), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("p5_rst");
    chk("p5_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    release_reset();
    mid_cycle(2);
    chk("p5_restart_req", 32'(imem_req), 32'd1);
    chk("p5_restart_addr", imem_addr, 32'h0);
    start_cycle(3);
    id_stall = 1'b1;

    // Phase 6: latency 3, fetch at 0xFFFF_FFFC wraps to 0
    enter_reset(3);
    id_stall = 1'b1;
    push_exp(32'h0);
    push_exp(32'hFFFF_FFFC);
    release_reset();
    wait_valid("p6_first_valid", 20);
    chk("p6_first_pc", pc_out, 32'h0);
    tick();
    id_stall = 1'b0;
    br = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    tick();
    br = 1'b0;
    wait_valid("p6_wrap_valid", 30);
    chk("p6_wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("p6_wrap_inst", inst_out, mem_word(32'hFFFF_FFFC));
    chk("p6_next_req", 32'(imem_req), 32'd1);
    chk("p6_next_addr", imem_addr, 32'h0);
    tick();
    id_stall = 1'b1;
    repeat (6) tick();
    chk("p6_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
